// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//
// Divides clk down to the pixel rate, runs horizontal and vertical raster
// counters and emits sync, blanking, coordinates and pixel/line/frame strobes.
// Every output comes straight from a flop, so all outputs are aligned to the
// same clk edge with no skew between them.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   en          in   count enable; 0 freezes the divider, counters and outputs
//   hsync       out  horizontal sync, level H_POL during the sync pulse
//   vsync       out  vertical sync, level V_POL during the sync pulse
//   video_on    out  1 inside the visible window
//   pix_x       out  horizontal count, 0..H_TOTAL-1
//   pix_y       out  vertical count, 0..V_TOTAL-1
//   pix_stb     out  one-clk pulse when the outputs move to a new pixel
//   line_start  out  pix_stb qualified with pix_x==0
//   frame_start out  pix_stb qualified with pix_x==0 and pix_y==0
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 29,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW_H     = 10,
  parameter int unsigned CW_V     = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic            hsync,
  output logic            vsync,
  output logic            video_on,
  output logic [CW_H-1:0] pix_x,
  output logic [CW_V-1:0] pix_y,
  output logic            pix_stb,
  output logic            line_start,
  output logic            frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;
  // One-bit divider when CLK_DIV==1; it then stays at 0 and ticks every enabled clk.
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0]   div_q, div_d;
  logic [CW_H-1:0] h_q, h_d;
  logic [CW_V-1:0] v_q, v_d;
  logic [CW_H-1:0] pix_x_q, pix_x_d;
  logic [CW_V-1:0] pix_y_q, pix_y_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            video_on_q, video_on_d;
  logic            pix_stb_q, pix_stb_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;

  logic            div_last_c;
  logic            h_last_c;
  logic            v_last_c;
  logic            tick_c;

  // Next-state: divider, raster counters and decode of the new (h,v).
  always_comb begin
    div_last_c    = (div_q == DW'(CLK_DIV - 1));
    h_last_c      = (h_q == CW_H'(H_TOTAL - 1));
    v_last_c      = (v_q == CW_V'(V_TOTAL - 1));
    tick_c        = en & div_last_c;

    div_d         = div_q;
    h_d           = h_q;
    v_d           = v_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;

    if (en) begin
      div_d = div_last_c ? '0 : div_q + DW'(1);
    end

    if (tick_c) begin
      h_d = h_last_c ? '0 : h_q + CW_H'(1);
      if (h_last_c) begin
        v_d = v_last_c ? '0 : v_q + CW_V'(1);
      end
    end

    // Level outputs only reload on a tick, so they hold their reset values
    // until the first pixel even though the counters reset to the last pixel.
    if (tick_c) begin
      pix_x_d    = h_d;
      pix_y_d    = v_d;
      video_on_d = (32'(h_d) < H_ACTIVE) && (32'(v_d) < V_ACTIVE);
      hsync_d    = ((32'(h_d) >= HS_BEG) && (32'(h_d) < HS_END)) ? H_POL : ~H_POL;
      vsync_d    = ((32'(v_d) >= VS_BEG) && (32'(v_d) < VS_END)) ? V_POL : ~V_POL;
    end

    pix_stb_d     = tick_c;
    line_start_d  = tick_c & (h_d == '0);
    frame_start_d = tick_c & (h_d == '0) & (v_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= DW'(CLK_DIV - 1);
      h_q           <= CW_H'(H_TOTAL - 1);
      v_q           <= CW_V'(V_TOTAL - 1);
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      video_on_q    <= 1'b0;
      pix_stb_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pix_stb_q     <= pix_stb_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_stb     = pix_stb_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// Instance a uses the default 640x480 timing; instance b uses a tiny
// 8x5 raster with CLK_DIV=1 and active-high hsync for frame-level checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       a_rst_n, a_en;
  logic       a_hsync, a_vsync, a_video_on, a_pix_stb, a_line_start, a_frame_start;
  logic [9:0] a_pix_x, a_pix_y;

  // Small-raster instance
  logic       b_rst_n, b_en;
  logic       b_hsync, b_vsync, b_video_on, b_pix_stb, b_line_start, b_frame_start;
  logic [2:0] b_pix_x, b_pix_y;

  int n_cmp = 0;
  int n_err = 0;

  vga_timing_gen u_dut_a (
    .clk         (clk),
    .rst_n       (a_rst_n),
    .en          (a_en),
    .hsync       (a_hsync),
    .vsync       (a_vsync),
    .video_on    (a_video_on),
    .pix_x       (a_pix_x),
    .pix_y       (a_pix_y),
    .pix_stb     (a_pix_stb),
    .line_start  (a_line_start),
    .frame_start (a_frame_start)
  );

  vga_timing_gen #(
    .CLK_DIV (1),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL   (1'b1), .V_POL(1'b0),
    .CW_H    (3), .CW_V(3)
  ) u_dut_b (
    .clk         (clk),
    .rst_n       (b_rst_n),
    .en          (b_en),
    .hsync       (b_hsync),
    .vsync       (b_vsync),
    .video_on    (b_video_on),
    .pix_x       (b_pix_x),
    .pix_y       (b_pix_y),
    .pix_stb     (b_pix_stb),
    .line_start  (b_line_start),
    .frame_start (b_frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hard stop in case a bounded loop is ever broken.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    int   w;
    int   fall_x, rise_x, vid_x, low_clk, low_stb, next_ls;
    int   stb_cnt, chg_cnt;
    logic prev_h, prev_v;
    logic [9:0] hold_x;
    int   ex, ey;

    a_rst_n = 1'b0; a_en = 1'b1;
    b_rst_n = 1'b0; b_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("a_rst_hsync",   32'(a_hsync),       1);
    check("a_rst_vsync",   32'(a_vsync),       1);
    check("a_rst_video",   32'(a_video_on),    0);
    check("a_rst_x",       32'(a_pix_x),       0);
    check("a_rst_y",       32'(a_pix_y),       0);
    check("a_rst_stb",     32'(a_pix_stb),     0);
    check("a_rst_frame",   32'(a_frame_start), 0);

    // First edge after release wraps to (0,0) and fires every strobe
    a_rst_n = 1'b1;
    @(negedge clk);
    check("a_first_frame", 32'(a_frame_start), 1);
    check("a_first_line",  32'(a_line_start),  1);
    check("a_first_stb",   32'(a_pix_stb),     1);
    check("a_first_x",     32'(a_pix_x),       0);
    check("a_first_y",     32'(a_pix_y),       0);
    check("a_first_video", 32'(a_video_on),    1);

    // pix_stb repeats every 4 clk
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("a_stb_period", 32'(a_pix_stb), (i == 4) ? 1 : 0);
    end
    check("a_x_after_4", 32'(a_pix_x), 1);

    // One full line: hsync window, video_on edge, line period
    k = 4; fall_x = -1; rise_x = -1; vid_x = -1; low_clk = 0; low_stb = 0; next_ls = -1;
    prev_h = a_hsync; prev_v = a_video_on;
    while (next_ls < 0 && k < 3400) begin
      @(negedge clk);
      k++;
      if (!a_hsync) begin
        low_clk++;
        if (a_pix_stb) low_stb++;
      end
      if (prev_h && !a_hsync) fall_x = 32'(a_pix_x);
      if (!prev_h && a_hsync) rise_x = 32'(a_pix_x);
      if (prev_v && !a_video_on) vid_x = 32'(a_pix_x);
      if (a_line_start) next_ls = k;
      prev_h = a_hsync; prev_v = a_video_on;
    end
    check("a_hs_fall_x",   32'(fall_x),  656);
    check("a_hs_rise_x",   32'(rise_x),  752);
    check("a_hs_low_clk",  32'(low_clk), 384);
    check("a_hs_low_stb",  32'(low_stb), 96);
    check("a_video_off_x", 32'(vid_x),   640);
    check("a_line_period", 32'(next_ls), 3200);
    check("a_line1_y",     32'(a_pix_y), 1);
    check("a_line1_frame", 32'(a_frame_start), 0);
    check("a_line1_vsync", 32'(a_vsync), 1);
    check("a_line1_video", 32'(a_video_on), 1);

    // Freeze for 37 clk one clk after the pix_x=100 tick
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(a_pix_stb && a_pix_x == 10'd100) && w < 1000);
    check("a_reach_x100", 32'(w < 1000), 1);
    @(negedge clk);
    a_en = 1'b0;
    hold_x = a_pix_x;
    stb_cnt = 0; chg_cnt = 0;
    repeat (37) begin
      @(negedge clk);
      if (a_pix_stb || a_line_start || a_frame_start) stb_cnt++;
      if (a_pix_x != hold_x || !a_video_on || !a_hsync) chg_cnt++;
    end
    check("a_frz_strobes", 32'(stb_cnt), 0);
    check("a_frz_changes", 32'(chg_cnt), 0);
    check("a_frz_x",       32'(a_pix_x), 100);
    a_en = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!a_pix_stb && w < 10);
    check("a_resume_wait", 32'(w), 3);
    check("a_resume_x",    32'(a_pix_x), 101);

    // Rest of the frozen line, then one whole line, counted in pixel strobes
    stb_cnt = 1; w = 0;
    do begin
      @(negedge clk);
      w++;
      if (a_pix_stb && !a_line_start) stb_cnt++;
    end while (!a_line_start && w < 4000);
    check("a_rest_stb", 32'(stb_cnt), 699);
    stb_cnt = 1; w = 0;
    do begin
      @(negedge clk);
      w++;
      if (a_pix_stb && !a_line_start) stb_cnt++;
    end while (!a_line_start && w < 4000);
    check("a_line_stb", 32'(stb_cnt), 800);
    check("a_line_clk", 32'(w), 3200);
    check("a_line3_y",  32'(a_pix_y), 3);

    // Asynchronous reset between edges
    repeat (50) @(negedge clk);
    check("a_pre_rst_video", 32'(a_video_on), 1);
    @(posedge clk);
    #2 a_rst_n = 1'b0;
    #1;
    check("a_arst_hsync", 32'(a_hsync),    1);
    check("a_arst_vsync", 32'(a_vsync),    1);
    check("a_arst_video", 32'(a_video_on), 0);
    check("a_arst_x",     32'(a_pix_x),    0);
    check("a_arst_y",     32'(a_pix_y),    0);
    @(negedge clk);
    a_rst_n = 1'b1;
    @(negedge clk);
    check("a_arst_frame", 32'(a_frame_start), 1);
    check("a_arst_x0",    32'(a_pix_x),       0);
    check("a_arst_video1", 32'(a_video_on),   1);

    // Small raster: reset levels, then two full frames against a hand model
    check("b_rst_hsync", 32'(b_hsync), 0);
    check("b_rst_vsync", 32'(b_vsync), 1);
    b_en = 1'b1;
    b_rst_n = 1'b1;
    for (int c = 0; c < 85; c++) begin
      @(negedge clk);
      ex = c % 8;
      ey = (c / 8) % 5;
      check("b_x",     32'(b_pix_x),       ex);
      check("b_y",     32'(b_pix_y),       ey);
      check("b_stb",   32'(b_pix_stb),     1);
      check("b_line",  32'(b_line_start),  (ex == 0) ? 1 : 0);
      check("b_frame", 32'(b_frame_start), (c % 40 == 0) ? 1 : 0);
      check("b_hsync", 32'(b_hsync),       (ex == 5 || ex == 6) ? 1 : 0);
      check("b_vsync", 32'(b_vsync),       (ey == 3) ? 0 : 1);
      check("b_video", 32'(b_video_on),    (ex < 4 && ey < 2) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
